// File: rtl/piso_pkg.sv
// Shared definitions for the serial shift-register link (transmitter and receiver).
//   PISO_WIDTH   : default word length on the link.
//   piso_state_t : transmitter FSM state encoding.
package piso_pkg;

  localparam int unsigned PISO_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

endpackage : piso_pkg

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter for the serial shift-register link.
// Accepts a WIDTH-bit word over valid/ready and sends it one bit per clock.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   din        : parallel word, sampled on the acceptance edge only
//   din_valid  : producer has a word on din
//   din_ready  : transmitter can accept a word this cycle
//   ser_out    : serial data bit
//   ser_valid  : ser_out carries a frame bit
//   ser_last   : current bit is the final bit of the frame
//   busy       : a frame is in progress
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_shift;
  logic             at_last;
  logic             accept;
  logic             head_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Decode from the flops; the link sees only flop-derived values.
  assign in_shift = (state_q == SHIFT);
  assign at_last  = in_shift && (cnt_q == LAST_CNT);
  assign accept   = din_valid && din_ready;

  // Head bit and one-position shift toward the head, zero-filling the tail.
  assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // FSM, shift register and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      // Covers both a fresh frame from IDLE and a gapless reload on the last bit.
      state_q <= SHIFT;
      shreg_q <= din;
      cnt_q   <= '0;
    end else if (in_shift) begin
      shreg_q <= shreg_shifted;
      if (at_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs.
  assign din_ready = !in_shift || (cnt_q == LAST_CNT);
  assign ser_valid = in_shift;
  assign busy      = in_shift;
  assign ser_out   = in_shift && head_bit;
  assign ser_last  = at_last;

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an LSB-first and an MSB-first instance share
// the same stimulus; outputs are sampled on the falling edge.
module tb_piso_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;

  logic l_ready, l_out, l_valid, l_last, l_busy;
  logic m_ready, m_out, m_valid, m_last, m_busy;

  int checks;
  int errors;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (l_ready),
    .ser_out   (l_out),
    .ser_valid (l_valid),
    .ser_last  (l_last),
    .busy      (l_busy)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (m_ready),
    .ser_out   (m_out),
    .ser_valid (m_valid),
    .ser_last  (m_last),
    .busy      (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " lsb ser_valid"}, l_valid, 1'b0);
    check({tag, " lsb ser_out"},   l_out,   1'b0);
    check({tag, " lsb ser_last"},  l_last,  1'b0);
    check({tag, " lsb busy"},      l_busy,  1'b0);
    check({tag, " lsb din_ready"}, l_ready, 1'b1);
    check({tag, " msb ser_valid"}, m_valid, 1'b0);
    check({tag, " msb ser_out"},   m_out,   1'b0);
    check({tag, " msb ser_last"},  m_last,  1'b0);
    check({tag, " msb busy"},      m_busy,  1'b0);
    check({tag, " msb din_ready"}, m_ready, 1'b1);
  endtask

  // One bit cycle of a frame: bit index i (0..7) of word w on both instances.
  task automatic check_bit(input string tag, input logic [W-1:0] w, input int i);
    logic last_exp;
    last_exp = (i == W - 1);
    check({tag, " lsb ser_valid"}, l_valid, 1'b1);
    check({tag, " lsb busy"},      l_busy,  1'b1);
    check({tag, " lsb ser_out"},   l_out,   w[i]);
    check({tag, " lsb ser_last"},  l_last,  last_exp);
    check({tag, " lsb din_ready"}, l_ready, last_exp);
    check({tag, " msb ser_valid"}, m_valid, 1'b1);
    check({tag, " msb ser_out"},   m_out,   w[W-1-i]);
    check({tag, " msb ser_last"},  m_last,  last_exp);
    check({tag, " msb din_ready"}, m_ready, last_exp);
  endtask

  initial begin
    logic [W-1:0] w;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;

    // Reset held with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle("reset_hold");
      din       = W'($urandom);
      din_valid = 1'($urandom);
    end
    @(negedge clk);
    check_idle("reset_hold_end");
    din_valid = 1'b0;
    rst       = 1'b1;

    // Single frame 8'h1E.
    @(negedge clk);
    check_idle("idle_pre_1e");
    w = 8'h1E;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("frame_1e", w, i);
      if (i == 0) din_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("idle_post_1e");

    // Back-to-back 8'hFF then 8'h00 with din_valid held high.
    din       = 8'hFF;
    din_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 8) check_bit("b2b_ff", 8'hFF, c);
      else       check_bit("b2b_00", 8'h00, c - 8);
      if (c == 0) din = 8'h00;
      if (c == 8) din_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("idle_post_b2b");

    // Reset mid-frame after 3 bits of 8'hA5, then 8'h81.
    w = 8'hA5;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("abort_a5", w, i);
      if (i == 0) din_valid = 1'b0;
    end
    #2 rst = 1'b0;
    #1 check_idle("reset_async");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_idle("reset_mid_hold");
      din       = W'($urandom);
      din_valid = 1'($urandom);
    end
    din_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check_idle("idle_after_abort");
    w = 8'h81;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("frame_81", w, i);
      if (i == 0) din_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("idle_post_81");

    // din and din_valid churn while not ready: only 8'h3C goes out.
    w = 8'h3C;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("unstable_3c", w, i);
      din       = W'($urandom);
      din_valid = (i < 6) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    check_idle("idle_post_3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_piso_tx
